// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one unified memory between the CPU and a loader port.
// Arbitrates, issues the access, waits out read latency, returns read data.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rd,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_adr,
  input  logic [DW-1:0] l_wd,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rd,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    C_ACC,
    L_ACC,
    RD_WAIT
  } state_t;

  state_t state_q, state_d;

  // own_q = 1 means the loader owns (or last owned) the memory
  logic          own_q, own_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [1:0]    lat_q, lat_d;
  logic [DW-1:0] c_rd_q, c_rd_d;
  logic [DW-1:0] l_rd_q, l_rd_d;
  logic          c_rv_q, c_rv_d;
  logic          l_rv_q, l_rv_d;

  logic l_keep;
  logic win_l;

  always_comb begin
    l_keep = l_lock && own_q
          && (burst_q < BW'(MAX_BURST));
    win_l  = 1'b0;
    if (l_req && !c_req) begin
      win_l = 1'b1;
    end else if (l_req && c_req) begin
      win_l = l_keep || !own_q;
    end
  end

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    burst_d = burst_q;
    lat_d   = lat_q;
    c_rd_d  = c_rd_q;
    l_rd_d  = l_rd_q;
    c_rv_d  = 1'b0;
    l_rv_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c_req || l_req) begin
          state_d = win_l ? L_ACC : C_ACC;
          own_d   = win_l;
          if (win_l && l_lock) begin
            if (burst_q != BW'(MAX_BURST)) begin
              burst_d = burst_q + BW'(1);
            end
          end else begin
            burst_d = '0;
          end
        end
      end
      C_ACC: begin
        if (c_we) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          lat_d   = 2'(RD_LAT);
        end
      end
      L_ACC: begin
        if (l_we) begin
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
          lat_d   = 2'(RD_LAT);
        end
      end
      RD_WAIT: begin
        if (lat_q <= 2'd1) begin
          state_d = IDLE;
          lat_d   = 2'd0;
          if (own_q) begin
            l_rd_d = mem_rd;
            l_rv_d = 1'b1;
          end else begin
            c_rd_d = mem_rd;
            c_rv_d = 1'b1;
          end
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      own_q   <= 1'b1;
      burst_q <= '0;
      lat_q   <= 2'd0;
      c_rd_q  <= '0;
      l_rd_q  <= '0;
      c_rv_q  <= 1'b0;
      l_rv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      burst_q <= burst_d;
      lat_q   <= lat_d;
      c_rd_q  <= c_rd_d;
      l_rd_q  <= l_rd_d;
      c_rv_q  <= c_rv_d;
      l_rv_q  <= l_rv_d;
    end
  end

  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    mem_adr = '0;
    mem_wd  = '0;
    unique case (1'b1)
      (state_q == C_ACC): begin
        mem_en  = 1'b1;
        mem_we  = c_we;
        mem_adr = c_adr;
        mem_wd  = c_wd;
      end
      (state_q == L_ACC): begin
        mem_en  = 1'b1;
        mem_we  = l_we;
        mem_adr = l_adr;
        mem_wd  = l_wd;
      end
      default: ;
    endcase
  end

  assign c_gnt    = (state_q == C_ACC);
  assign l_gnt    = (state_q == L_ACC);
  assign c_rvalid = c_rv_q;
  assign l_rvalid = l_rv_q;
  assign c_rd     = c_rd_q;
  assign l_rd     = l_rd_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Drivers push expected grants/read returns; a monitor pops and compares.
module tb_mem_arbiter;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int RD_LAT    = 3;
  localparam int MAX_BURST = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we;
  logic [AW-1:0] c_adr;
  logic [DW-1:0] c_wd;
  logic          c_gnt, c_rvalid;
  logic [DW-1:0] c_rd;
  logic          l_req, l_we, l_lock;
  logic [AW-1:0] l_adr;
  logic [DW-1:0] l_wd;
  logic          l_gnt, l_rvalid;
  logic [DW-1:0] l_rd;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          busy;

  mem_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_adr(c_adr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
    .l_req(l_req), .l_we(l_we), .l_adr(l_adr), .l_wd(l_wd),
    .l_lock(l_lock), .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rd(l_rd),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: data appears RD_LAT cycles after the mem_en cycle
  logic [DW-1:0] mem  [256]    = '{default: '0};
  logic [DW-1:0] pipe [RD_LAT] = '{default: '0};
  always @(posedge clk) begin
    pipe[0] <= mem[mem_adr[9:2]];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    if (mem_en && mem_we) mem[mem_adr[9:2]] <= mem_wd;
  end
  assign mem_rd = pipe[RD_LAT-1];

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, want, cyc);
    end
  endfunction

  typedef struct {
    int          port;
    int          kind;
    int          cyc;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] ord;
  } ev_t;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wd;
    logic        lock;
  } txn_t;

  ev_t sb[$];

  function automatic void exp_gnt(input int p, input int c,
                                  input logic we,
                                  input logic [31:0] adr,
                                  input logic [31:0] wd);
    sb.push_back('{p, 0, c, we, adr, wd, 32'h0, 32'h0});
  endfunction

  function automatic void exp_rv(input int p, input int c,
                                 input logic [31:0] rd,
                                 input logic [31:0] ord);
    sb.push_back('{p, 1, c, 1'b0, 32'h0, 32'h0, rd, ord});
  endfunction

  function automatic txn_t mk(input logic we, input logic [31:0] adr,
                              input logic [31:0] wd, input logic lock);
    txn_t t;
    t.we = we; t.adr = adr; t.wd = wd; t.lock = lock;
    return t;
  endfunction

  ev_t e;
  always @(negedge clk) begin
    if ((c_gnt | l_gnt | c_rvalid | l_rvalid) === 1'b1) begin
      chk("ev_onehot",
          32'($countones({c_gnt, l_gnt, c_rvalid, l_rvalid})), 1);
      if (sb.size() == 0) begin
        chk("ev_unexpected", {c_gnt, l_gnt, c_rvalid, l_rvalid}, 0);
      end else begin
        e = sb.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        if (e.kind == 0) begin
          chk("gnt_port", {c_gnt, l_gnt},
              (e.port == 0) ? 2'b10 : 2'b01);
          chk("gnt_mem_en", mem_en, 1);
          chk("gnt_mem_we", mem_we, e.we);
          chk("gnt_mem_adr", mem_adr, e.adr);
          chk("gnt_mem_wd", mem_wd, e.wd);
          chk("gnt_busy", busy, 1);
        end else begin
          chk("rv_port", {c_rvalid, l_rvalid},
              (e.port == 0) ? 2'b10 : 2'b01);
          chk("rv_rd", (e.port == 0) ? c_rd : l_rd, e.rd);
          chk("rv_other_rd", (e.port == 0) ? l_rd : c_rd, e.ord);
          chk("rv_busy", busy, 0);
        end
      end
    end
  end

  // a pending request must stay up until its grant
  logic c_pend = 1'b0;
  logic l_pend = 1'b0;
  always @(posedge clk) begin
    if (reset && c_pend) chk("c_req_held", c_req, 1);
    if (reset && l_pend) chk("l_req_held", l_req, 1);
    c_pend <= reset && c_req && !c_gnt;
    l_pend <= reset && l_req && !l_gnt;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv_c(input txn_t q[$], input int dly);
    logic got;
    tick(dly);
    foreach (q[i]) begin
      c_req = 1'b1; c_we = q[i].we; c_adr = q[i].adr; c_wd = q[i].wd;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        got = c_gnt;
      end
      chk("c_gnt_wait", got, 1);
      tick(1);
    end
    c_req = 1'b0; c_we = 1'b0; c_adr = '0; c_wd = '0;
  endtask

  task automatic drv_l(input txn_t q[$], input int dly);
    logic got;
    tick(dly);
    foreach (q[i]) begin
      l_req = 1'b1; l_we = q[i].we; l_adr = q[i].adr;
      l_wd = q[i].wd; l_lock = q[i].lock;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
        @(negedge clk);
        got = l_gnt;
      end
      chk("l_gnt_wait", got, 1);
      tick(1);
    end
    l_req = 1'b0; l_we = 1'b0; l_adr = '0; l_wd = '0; l_lock = 1'b0;
  endtask

  task automatic settle();
    tick(6);
    chk("sb_drain", sb.size(), 0);
  endtask

  task automatic rst_chk();
    chk("rst_gnt", {c_gnt, l_gnt}, 0);
    chk("rst_rvalid", {c_rvalid, l_rvalid}, 0);
    chk("rst_mem_en_we", {mem_en, mem_we}, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_c_rd", c_rd, 0);
    chk("rst_l_rd", l_rd, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    txn_t cq[$];
    txn_t lq[$];

    // reset with both requesters already up
    reset = 1'b0;
    c_req = 1'b1; c_we = 1'b1; c_adr = 32'h100; c_wd = 32'h11;
    l_req = 1'b1; l_we = 1'b1; l_adr = 32'h104; l_wd = 32'h22;
    l_lock = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      rst_chk();
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    t0 = cyc;
    exp_gnt(0, t0 + 1, 1'b1, 32'h100, 32'h11);
    exp_gnt(1, t0 + 3, 1'b1, 32'h104, 32'h22);
    cq = {mk(1'b1, 32'h100, 32'h11, 1'b0)};
    lq = {mk(1'b1, 32'h104, 32'h22, 1'b0)};
    fork
      drv_c(cq, 0);
      drv_l(lq, 0);
    join
    settle();

    // CPU write then read back
    t0 = cyc;
    exp_gnt(0, t0 + 1, 1'b1, 32'h40, 32'hDEADBEEF);
    exp_gnt(0, t0 + 3, 1'b0, 32'h40, 32'h0);
    exp_rv(0, t0 + 3 + RD_LAT + 1, 32'hDEADBEEF, 32'h0);
    cq = {mk(1'b1, 32'h40, 32'hDEADBEEF, 1'b0),
          mk(1'b0, 32'h40, 32'h0, 1'b0)};
    drv_c(cq, 0);
    settle();

    // loader preloads a word; leaves loader as last owner
    t0 = cyc;
    exp_gnt(1, t0 + 1, 1'b1, 32'h80, 32'h12345678);
    lq = {mk(1'b1, 32'h80, 32'h12345678, 1'b0)};
    drv_l(lq, 0);
    settle();

    // contention, no lock: strict alternation starting with CPU
    t0 = cyc;
    cq = {};
    lq = {};
    for (int i = 0; i < 4; i++) begin
      exp_gnt(0, t0 + 1 + 4*i, 1'b1, 32'h200 + 4*i, 32'hC0 + i);
      exp_gnt(1, t0 + 3 + 4*i, 1'b1, 32'h300 + 4*i, 32'hA0 + i);
      cq.push_back(mk(1'b1, 32'h200 + 4*i, 32'hC0 + i, 1'b0));
      lq.push_back(mk(1'b1, 32'h300 + 4*i, 32'hA0 + i, 1'b0));
    end
    fork
      drv_c(cq, 0);
      drv_l(lq, 0);
    join
    settle();

    // locked burst: 8 loader grants, one CPU slot, loader resumes
    t0 = cyc;
    lq = {};
    for (int k = 1; k <= 12; k++) begin
      lq.push_back(mk(1'b1, 32'h400 + 4*(k-1), 32'hB0 + k - 1, 1'b1));
    end
    for (int k = 1; k <= 8; k++) begin
      exp_gnt(1, t0 + 2*k - 1, 1'b1, 32'h400 + 4*(k-1), 32'hB0 + k - 1);
    end
    exp_gnt(0, t0 + 17, 1'b1, 32'h500, 32'hCC);
    for (int k = 9; k <= 12; k++) begin
      exp_gnt(1, t0 + 2*k + 1, 1'b1, 32'h400 + 4*(k-1), 32'hB0 + k - 1);
    end
    cq = {mk(1'b1, 32'h500, 32'hCC, 1'b0)};
    fork
      drv_l(lq, 0);
      drv_c(cq, 3);
    join
    settle();

    // loader read, CPU waits through RD_WAIT
    t0 = cyc;
    exp_gnt(1, t0 + 1, 1'b0, 32'h80, 32'h0);
    exp_rv(1, t0 + RD_LAT + 2, 32'h12345678, 32'hDEADBEEF);
    exp_gnt(0, t0 + RD_LAT + 3, 1'b1, 32'h44, 32'h55);
    lq = {mk(1'b0, 32'h80, 32'h0, 1'b0)};
    cq = {mk(1'b1, 32'h44, 32'h55, 1'b0)};
    fork
      drv_l(lq, 0);
      drv_c(cq, 2);
      begin
        tick(3);
        @(negedge clk);
        chk("wait_mem_en", mem_en, 0);
        chk("wait_mem_adr", mem_adr, 0);
        chk("wait_mem_wd", mem_wd, 0);
        chk("wait_c_gnt", c_gnt, 0);
        chk("wait_busy", busy, 1);
      end
    join
    settle();
    chk("hold_c_rd", c_rd, 32'hDEADBEEF);
    chk("hold_l_rd", l_rd, 32'h12345678);

    // reset while a loader read is in RD_WAIT
    t0 = cyc;
    exp_gnt(1, t0 + 1, 1'b0, 32'h80, 32'h0);
    exp_gnt(0, t0 + 6, 1'b1, 32'h48, 32'h77);
    lq = {mk(1'b0, 32'h80, 32'h0, 1'b0)};
    cq = {mk(1'b1, 32'h48, 32'h77, 1'b0)};
    fork
      drv_l(lq, 0);
      drv_c(cq, 5);
      begin
        tick(3);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        @(negedge clk);
        chk("mr_rvalid", {c_rvalid, l_rvalid}, 0);
        chk("mr_l_rd", l_rd, 0);
        chk("mr_c_rd", c_rd, 0);
        chk("mr_busy", busy, 0);
        @(negedge clk);
        chk("mr_no_late_rv", l_rvalid, 0);
      end
    join
    settle();
    chk("post_c_rd", c_rd, 0);
    chk("post_l_rd", l_rd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
